// File: rtl/y_multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing with
// illegal-instruction and memory-timeout halts plus a retired-instruction count.
module y_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [2:0]  op,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic        Link,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [2:0] C_R   = 3'd0;
  localparam logic [2:0] C_I   = 3'd1;
  localparam logic [2:0] C_LW  = 3'd2;
  localparam logic [2:0] C_SW  = 3'd3;
  localparam logic [2:0] C_BEQ = 3'd4;
  localparam logic [2:0] C_JAL = 3'd5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [2:0]  cls;
  logic [7:0]  wait_cnt;
  logic [31:0] instret_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        dec_ok;
  logic [2:0]  dec_cls;
  logic [2:0]  dec_op;
  logic        dec_alusrc;
  logic        unused_ins;

  assign opcode     = ins[6:0];
  assign f3         = ins[14:12];
  assign f7         = ins[31:25];
  assign unused_ins = ^{ins[24:15], ins[11:7]};

  always_comb begin
    dec_ok     = 1'b1;
    dec_cls    = C_R;
    dec_op     = OP_ADD;
    dec_alusrc = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_cls = C_R;
        case ({f7, f3})
          10'b0000000_000: dec_op = OP_ADD;
          10'b0100000_000: dec_op = OP_SUB;
          10'b0000000_111: dec_op = OP_AND;
          10'b0000000_110: dec_op = OP_OR;
          10'b0000000_010: dec_op = OP_SLT;
          default:         dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_cls    = C_I;
        dec_alusrc = 1'b1;
        case (f3)
          3'b000:  dec_op = OP_ADD;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          3'b010:  dec_op = OP_SLT;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_cls    = C_LW;
        dec_alusrc = 1'b1;
        dec_ok     = (f3 == 3'b010);
      end
      7'b0100011: begin
        dec_cls    = C_SW;
        dec_alusrc = 1'b1;
        dec_ok     = (f3 == 3'b010);
      end
      7'b1100011: begin
        dec_cls = C_BEQ;
        dec_op  = OP_SUB;
        dec_ok  = (f3 == 3'b000);
      end
      7'b1101111: dec_cls = C_JAL;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cls       <= C_R;
      op        <= 3'b000;
      ALUSrc    <= 1'b0;
      err       <= 2'b00;
      wait_cnt  <= 8'd0;
      instret_q <= 32'd0;
    end else begin
      if (PCWrite) instret_q <= instret_q + 32'd1;
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (dec_ok) begin
            cls    <= dec_cls;
            op     <= dec_op;
            ALUSrc <= dec_alusrc;
            state  <= S_EXEC;
          end else begin
            err   <= 2'b01;
            state <= S_HALT;
          end
        end
        S_EXEC: begin
          case (cls)
            C_LW, C_SW: begin
              wait_cnt <= 8'd0;
              state    <= S_MEM;
            end
            C_BEQ, C_JAL: state <= S_FETCH;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= 8'd0;
            state    <= (cls == C_SW) ? S_FETCH : S_WB;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            // this is the MEM_TIMEOUT-th consecutive stalled cycle
            wait_cnt <= 8'd0;
            err      <= 2'b10;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // Strobes decode straight from state so reset and HALT silence them at once.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    Link     = 1'b0;
    case (state)
      S_FETCH: IRWrite = 1'b1;
      S_EXEC: begin
        if (cls == C_BEQ) begin
          PCWrite = 1'b1;
          PCSrc   = zero ? 2'b01 : 2'b00;
        end else if (cls == C_JAL) begin
          PCWrite  = 1'b1;
          PCSrc    = 2'b10;
          RegWrite = 1'b1;
          Link     = 1'b1;
        end
      end
      S_MEM: begin
        MemRead  = (cls == C_LW);
        MemWrite = (cls == C_SW);
        PCWrite  = mem_ready && (cls == C_SW);
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        Mem2Reg  = (cls == C_LW);
      end
      default: ;
    endcase
  end

  assign halted  = (state == S_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_y_multicycle_ctrl.sv
// Bench for y_multicycle_ctrl: per-cycle expected control vectors are queued as
// each instruction is driven and compared at the falling edge.
module tb_y_multicycle_ctrl;
  localparam int TO = 15;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  logic        clk, rst_n, run, zero, mem_ready;
  logic [31:0] ins;
  logic        IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, Link, halted;
  logic [1:0]  PCSrc, err;
  logic [2:0]  op, state;
  logic [31:0] instret;

  y_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem2Reg(Mem2Reg), .Link(Link), .state(state), .halted(halted), .err(err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [14:0] vec;
    bit         chk_op;
    bit         chk_alu;
    logic [2:0] op;
    logic       alu;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret;
  logic [14:0] obs;

  assign obs = {state, IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite,
                Mem2Reg, Link, halted, err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [14:0] mkv(input logic [2:0] st, input logic irw, input logic pcw,
                                      input logic [1:0] src, input logic rw, input logic mr,
                                      input logic mw, input logic m2r, input logic lnk,
                                      input logic hlt, input logic [1:0] e);
    return {st, irw, pcw, src, rw, mr, mw, m2r, lnk, hlt, e};
  endfunction

  task automatic push(input string tag, input logic [14:0] v, input bit co, input bit ca,
                      input logic [2:0] o, input logic a);
    exp_t e;
    e.tag = tag; e.vec = v; e.chk_op = co; e.chk_alu = ca; e.op = o; e.alu = a;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.tag, "/ctl"}, 32'(obs), 32'(mon_e.vec));
      if (mon_e.chk_op)  chk({mon_e.tag, "/op"}, 32'(op), 32'(mon_e.op));
      if (mon_e.chk_alu) chk({mon_e.tag, "/alusrc"}, 32'(ALUSrc), 32'(mon_e.alu));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one tick after the edge that put the DUT in FETCH; leaves likewise.
  task automatic do_ins(input string tag, input logic [31:0] w, input int kind, input logic z,
                        input int nwait, input logic [2:0] eop, input logic ealu);
    logic [14:0] v;
    logic        mr, mw;
    bit          ca;
    ca = (kind != K_JAL);
    ins = w; zero = z; mem_ready = 1'b0;
    push(tag, mkv(3'd1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 0, 0, 3'd0, 0); step();
    push(tag, mkv(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 0, 0, 3'd0, 0); step();
    if (kind == K_ILL) begin
      repeat (3) begin
        push(tag, mkv(3'd7, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd1), 0, 0, 3'd0, 0); step();
      end
      chk({tag, "/instret"}, instret, exp_instret);
      return;
    end
    case (kind)
      K_BEQ:   v = mkv(3'd3, 0, 1, z ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
      K_JAL:   v = mkv(3'd3, 0, 1, 2'd2, 1, 0, 0, 0, 1, 0, 2'd0);
      default: v = mkv(3'd3, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    endcase
    push(tag, v, 1, ca, eop, ealu); step();
    if (kind == K_LW || kind == K_SW) begin
      mr = (kind == K_LW);
      mw = (kind == K_SW);
      if (nwait >= TO) begin
        repeat (TO) begin
          push(tag, mkv(3'd4, 0, 0, 2'd0, 0, mr, mw, 0, 0, 0, 2'd0), 1, 1, eop, ealu); step();
        end
        repeat (3) begin
          push(tag, mkv(3'd7, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd2), 0, 0, 3'd0, 0); step();
        end
        chk({tag, "/instret"}, instret, exp_instret);
        return;
      end
      repeat (nwait) begin
        push(tag, mkv(3'd4, 0, 0, 2'd0, 0, mr, mw, 0, 0, 0, 2'd0), 1, 1, eop, ealu); step();
      end
      mem_ready = 1'b1;
      push(tag, mkv(3'd4, 0, mw, 2'd0, 0, mr, mw, 0, 0, 0, 2'd0), 1, 1, eop, ealu); step();
      mem_ready = 1'b0;
    end
    if (kind == K_R || kind == K_I || kind == K_LW) begin
      push(tag, mkv(3'd5, 0, 1, 2'd0, 1, 0, 0, kind == K_LW, 0, 0, 2'd0), 1, 1, eop, ealu);
      step();
    end
    exp_instret = exp_instret + 32'd1;
    chk({tag, "/instret"}, instret, exp_instret);
  endtask

  task automatic start_run(input string tag);
    run = 1'b1;
    push(tag, mkv(3'd0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 0, 0, 3'd0, 0);
    step();
  endtask

  initial begin
    clk = 0; rst_n = 0; run = 0; zero = 0; mem_ready = 0; ins = 32'd0;
    exp_instret = 32'd0;
    #12;
    chk("rst/ctl", 32'(obs), 32'd0);
    chk("rst/op_alusrc", 32'({op, ALUSrc}), 32'd0);
    chk("rst/instret", instret, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_norun/state", 32'(state), 32'd0);

    start_run("start");
    do_ins("add",   32'h002081B3, K_R,   0, 0, 3'b010, 0);
    run = 1'b0;  // must not disturb the running sequence
    do_ins("lw3",   32'h0080A283, K_LW,  0, 3, 3'b010, 1);
    do_ins("beq1",  32'h00208463, K_BEQ, 1, 0, 3'b110, 0);
    do_ins("beq0",  32'h00208463, K_BEQ, 0, 0, 3'b110, 0);
    do_ins("jal",   32'h010000EF, K_JAL, 0, 0, 3'b010, 0);
    do_ins("sw2",   32'h0050A623, K_SW,  0, 2, 3'b010, 1);
    do_ins("sw14",  32'h0050A623, K_SW,  0, TO - 1, 3'b010, 1);
    do_ins("ori",   32'h0030E113, K_I,   0, 0, 3'b001, 1);
    do_ins("andi",  32'h0030F113, K_I,   0, 0, 3'b000, 1);
    do_ins("slti",  32'h0050A113, K_I,   0, 0, 3'b111, 1);
    do_ins("sub",   32'h402081B3, K_R,   0, 0, 3'b110, 0);
    do_ins("and",   32'h0020F1B3, K_R,   0, 0, 3'b000, 0);
    do_ins("or",    32'h0020E1B3, K_R,   0, 0, 3'b001, 0);
    do_ins("slt",   32'h0020A1B3, K_R,   0, 0, 3'b111, 0);
    do_ins("ill",   32'h00000000, K_ILL, 0, 0, 3'b000, 0);

    rst_n = 1'b0;
    #1;
    chk("rst2/ctl", 32'(obs), 32'd0);
    chk("rst2/instret", instret, 32'd0);
    exp_instret = 32'd0;
    step();
    rst_n = 1'b1;
    start_run("start2");
    do_ins("sw_to", 32'h0050A623, K_SW, 0, TO, 3'b010, 1);

    rst_n = 1'b0;
    #1;
    chk("rst3/ctl", 32'(obs), 32'd0);
    exp_instret = 32'd0;
    step();
    rst_n = 1'b1;
    start_run("start3");
    do_ins("add2", 32'h002081B3, K_R, 0, 0, 3'b010, 0);
    ins = 32'h0080A283;
    mem_ready = 1'b0;
    repeat (4) step();
    chk("abort/state_pre", 32'(state), 32'd4);
    chk("abort/memread_pre", 32'(MemRead), 32'd1);
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort/state", 32'(state), 32'd0);
    chk("abort/memread", 32'(MemRead), 32'd0);
    chk("abort/instret", instret, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("abort/idle_norun", 32'(state), 32'd0);

    dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    start_run("start4");
    do_ins("wrap", 32'h002081B3, K_R, 0, 0, 3'b010, 0);
    chk("wrap/zero", instret, 32'd0);

    step();
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/y_multicycle_ctrl.md
Y_MULTICYCLE_CTRL -- requirements
Module: y_multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum MEM-state cycles spent waiting for mem_ready before an error halt (range 1..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; leaves IDLE when high.
REQ-005 ins  input  32  current instruction word from the fetch stage.
REQ-006 zero  input  1  ALU result-is-zero flag, sampled in EXEC.
REQ-007 mem_ready  input  1  data-memory access complete, sampled in MEM.
REQ-008 IRWrite  output  1  latch instruction.
REQ-009 PCWrite  output  1  update PC.
REQ-010 PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jal target.
REQ-011 RegWrite  output  1  register-file write enable.
REQ-012 ALUSrc  output  1  0 = rd2, 1 = immediate.
REQ-013 op  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-014 MemRead, MemWrite  output  1 each  data-memory strobes.
REQ-015 Mem2Reg  output  1  writeback select: 0 = ALU, 1 = memory.
REQ-016 Link  output  1  writeback of PC+4 (jal); overrides Mem2Reg.
REQ-017 state  output  3  IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 7.
REQ-018 halted  output  1  high in HALT.
REQ-019 err  output  2  00 none, 01 illegal instruction, 10 memory timeout.
REQ-020 instret  output  32  retired-instruction counter.

Function
REQ-021 IDLE→FETCH when run=1; otherwise stay in IDLE.
REQ-022 FETCH: IRWrite=1 for exactly one cycle; next state DECODE.
REQ-023 DECODE: classify ins[6:0] and register op/ALUSrc; registered values hold until the instruction retires.
- R-type 0110011: funct3/funct7 000/0000000 add, 000/0100000 sub, 111/0 and, 110/0 or, 010/0 slt; ALUSrc=0.
- I-ALU 0010011: funct3 000 add, 110 or, 111 and, 010 slt; ALUSrc=1.
- lw 0000011 and sw 0100011 (funct3 010): op add, ALUSrc=1.
- beq 1100011 (funct3 000): op sub, ALUSrc=0.
- jal 1101111: op add.
REQ-024 Any other opcode or funct combination in DECODE → HALT with err=01 and no PCWrite.
REQ-025 EXEC next state by class:
- R-type, I-ALU → WB.
- lw, sw → MEM.
- beq → FETCH, with PCWrite=1 and PCSrc=01 if zero=1, else PCSrc=00.
- jal → FETCH, with RegWrite=1, Link=1, PCWrite=1, PCSrc=10.
REQ-026 MEM: MemRead (lw) or MemWrite (sw) held high throughout the state; leave MEM on the cycle mem_ready=1.
- lw → WB.
- sw → FETCH, with PCWrite=1 and PCSrc=00.
REQ-027 MEM wait counter: a MEM_TIMEOUT-th consecutive cycle with mem_ready=0 → HALT with err=10; strobes drop on entering HALT.
REQ-028 WB: RegWrite=1 for one cycle, Mem2Reg=1 for lw (0 otherwise), PCWrite=1, PCSrc=00; next state FETCH.
REQ-029 Latencies in cycles from FETCH to the next FETCH: beq/jal 3; R/I/sw 4; lw 5 (plus memory wait cycles).
REQ-030 RegWrite, PCWrite and IRWrite are single-cycle pulses; RegWrite and MemWrite are never high in the same cycle.
REQ-031 instret increments by 1 on every PCWrite pulse and wraps 0xFFFFFFFF→0.
REQ-032 run is sampled only in IDLE; deasserting run mid-instruction has no effect.
REQ-033 HALT is absorbing; only rst_n exits it.

Reset
REQ-034 rst_n=0 forces, asynchronously:
- state IDLE;
- all strobes, PCSrc, op, ALUSrc, Mem2Reg, Link, halted, err, instret and the wait counter to 0.
REQ-035 Reset asserted mid-instruction aborts it with no further strobes; after release, the first FETCH requires run=1.

Verification
REQ-036 run=1, ins=0x002081B3 (add) → states 1,2,3,5; op=010, ALUSrc=0; RegWrite pulse in WB; instret 0→1.
REQ-037 ins=0x0080A283 (lw), mem_ready low for 3 MEM cycles → MemRead high 4 cycles; WB with Mem2Reg=1; FETCH-to-FETCH in 8 cycles.
REQ-038 ins=0x00208463 (beq), zero=1 → PCSrc=01 and PCWrite in EXEC; with zero=0 → PCSrc=00; 3 cycles each.
REQ-039 ins=0x010000EF (jal) → EXEC shows RegWrite=1, Link=1, PCSrc=10; ins=0x0050A623 (sw) → MemWrite high, RegWrite never high.
REQ-040 ins=0x00000000 → HALT, err=01, halted=1, instret unchanged; sw with mem_ready=0 for 15 cycles → HALT, err=10.
REQ-041 rst_n pulsed low during lw MEM → immediate IDLE, MemRead=0, instret=0; preload instret 0xFFFFFFFF then retire one instruction → 0.
